stack_block_sequencer: RTL

// - Sequences the V30MZ PUSHA/POPA block transfer between the 8-entry register file and the stack.
// - Issues 8 stack bus transfers in architectural order, then updates SP.
// - For POPA, writes popped words into the register file through its single write port.
// - Sits between the execution-unit control and the register file write port; the BIU serves the bus side.

---
 rtl/stack_block_sequencer_if.sv | 29 ++
 rtl/stack_block_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/stack_block_sequencer_if.sv
// Stack bus and register-file write port of the PUSHA/POPA block sequencer.
// master = sequencer side, slave = BIU / register file side.
interface stack_block_sequencer_if;
    // mem_req/mem_addr/mem_we/mem_wdata are held stable while mem_req=1 until the
    // cycle mem_ack=1 completes the transfer; mem_rdata is valid only in that cycle,
    // and mem_ack with mem_req=0 carries no meaning.
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        rf_we;
    logic [1:0]  rf_write_part;
    logic [2:0]  rf_write_id;
    logic [15:0] rf_write_data;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        output rf_we, rf_write_part, rf_write_id, rf_write_data,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  rf_we, rf_write_part, rf_write_id, rf_write_data,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/stack_block_sequencer.sv
// V30MZ PUSHA/POPA sequencer: 8 stack transfers in architectural order, then SP update.
// Optional macro STACK_SEQ_POPA_SKIP_SP_EN drops the bus read of the SP slot during POPA.
module stack_block_sequencer #(
    parameter int NUM_REGISTERS = 8,
    parameter int SP_INDEX      = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               op,
    input  logic [NUM_REGISTERS-1:0][15:0]     registers,
    output logic                               busy,
    output logic                               done,
    output logic [1:0]                         state_dbg,
    stack_block_sequencer_if.master            bus
);
    typedef enum logic [1:0] {IDLE, XFER, DRAIN, FINISH} state_t;

    localparam logic [2:0]  LAST_ID = 3'(NUM_REGISTERS - 1);
    localparam logic [2:0]  SP_ID   = 3'(SP_INDEX);
    localparam logic [15:0] FRAME   = 16'(2 * NUM_REGISTERS);

    state_t                         state_q, state_d;
    logic [2:0]                     k_q, k_d, k_next;
    logic                           pop_q;
    logic [NUM_REGISTERS-1:0][15:0] snap_q;
    logic [15:0]                    sp0;
    logic                           capture;
    logic                           req_q, req_d, we_q, we_d;
    logic [15:0]                    addr_q, addr_d, wdata_q, wdata_d;
    logic                           rf_we_q, rf_we_d, done_q, done_d;
    logic [2:0]                     rf_id_q, rf_id_d;
    logic [15:0]                    rf_data_q, rf_data_d;

    assign sp0 = snap_q[SP_INDEX];

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rf_we_d   = 1'b0;
        rf_id_d   = 3'd0;
        rf_data_d = 16'd0;
        done_d    = 1'b0;
        capture   = 1'b0;
        k_next    = k_q + 3'd1;
`ifdef STACK_SEQ_POPA_SKIP_SP_EN
        // The SP slot is never read during POPA; hop straight over its address.
        if (pop_q && (LAST_ID - k_next) == SP_ID) begin
            k_next = k_q + 3'd2;
        end
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = XFER;
                    k_d     = 3'd0;
                    req_d   = 1'b1;
                    we_d    = ~op;
                    addr_d  = op ? registers[SP_INDEX] : registers[SP_INDEX] - 16'd2;
                    wdata_d = op ? 16'd0 : registers[0];
                end
            end
            XFER: begin
                if (bus.mem_ack) begin
                    // Popped SP word is discarded; SP is only written in FINISH.
                    if (pop_q && (LAST_ID - k_q) != SP_ID) begin
                        rf_we_d   = 1'b1;
                        rf_id_d   = LAST_ID - k_q;
                        rf_data_d = bus.mem_rdata;
                    end
                    if (k_q == LAST_ID) begin
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        addr_d  = 16'd0;
                        wdata_d = 16'd0;
                        if (pop_q) begin
                            state_d = DRAIN;
                        end else begin
                            state_d   = FINISH;
                            rf_we_d   = 1'b1;
                            rf_id_d   = SP_ID;
                            rf_data_d = sp0 - FRAME;
                            done_d    = 1'b1;
                        end
                    end else begin
                        k_d     = k_next;
                        addr_d  = pop_q ? sp0 + {12'd0, k_next, 1'b0}
                                        : sp0 - {12'd0, k_next, 1'b0} - 16'd2;
                        wdata_d = pop_q ? 16'd0 : snap_q[k_next];
                    end
                end
            end
            DRAIN: begin
                state_d   = FINISH;
                rf_we_d   = 1'b1;
                rf_id_d   = SP_ID;
                rf_data_d = sp0 + FRAME;
                done_d    = 1'b1;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= 3'd0;
            pop_q     <= 1'b0;
            snap_q    <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 16'd0;
            wdata_q   <= 16'd0;
            rf_we_q   <= 1'b0;
            rf_id_q   <= 3'd0;
            rf_data_q <= 16'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rf_we_q   <= rf_we_d;
            rf_id_q   <= rf_id_d;
            rf_data_q <= rf_data_d;
            done_q    <= done_d;
            if (capture) begin
                pop_q  <= op;
                snap_q <= registers;
            end
        end
    end

    assign busy              = (state_q != IDLE);
    assign done              = done_q;
    assign state_dbg         = state_q;
    assign bus.mem_req       = req_q;
    assign bus.mem_we        = we_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.rf_we         = rf_we_q;
    assign bus.rf_write_part = {2{rf_we_q}};
    assign bus.rf_write_id   = rf_id_q;
    assign bus.rf_write_data = rf_data_q;
endmodule
